// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester round-robin arbiter with exclusive lock for one BRAM port
//
// Shares a single RAM port between requesters A and B. Grants are combinational,
// at most one per cycle, and a granted requester sees o_ack_x one cycle later
// together with the RAM's registered read data. A requester granted with its
// lock input high keeps sole ownership until it drops the lock.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_req_x, i_write_x           request and direction (1 = write) from A / B
//   i_addr_x, i_data_x           address and write data from A / B
//   i_lock_x                     request or hold exclusive ownership
//   o_gnt_x                      request accepted this cycle
//   o_ack_x, o_data_x            response one cycle after the grant
//   o_mem_addr/data/write        RAM port drive
//   i_mem_data                   RAM registered read data (write-first)
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_a,
  input  logic                  i_req_b,
  input  logic                  i_write_a,
  input  logic                  i_write_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_lock_a,
  input  logic                  i_lock_b,
  output logic                  o_gnt_a,
  output logic                  o_gnt_b,
  output logic                  o_ack_a,
  output logic                  o_ack_b,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_b;   // 1 = B was served most recently, so A wins the next tie
  logic   r_ack_a;
  logic   r_ack_b;
  logic   w_gnt_a;
  logic   w_gnt_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= FREE;
      r_last_b <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_gnt_a || w_gnt_b) begin
        r_last_b <= w_gnt_b;
      end
      r_ack_a <= w_gnt_a;
      r_ack_b <= w_gnt_b;
    end
  end

  // A held lock restricts the grant to its owner. When the owner drops its
  // lock, that same cycle falls through to normal FREE arbitration.
  always_comb begin
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_next_state = r_state;
    if (r_state == LOCK_A && i_lock_a) begin
      w_gnt_a = i_req_a;
    end else if (r_state == LOCK_B && i_lock_b) begin
      w_gnt_b = i_req_b;
    end else begin
      w_next_state = FREE;
      if (i_req_a && i_req_b) begin
        w_gnt_a = r_last_b;
        w_gnt_b = !r_last_b;
      end else begin
        w_gnt_a = i_req_a;
        w_gnt_b = i_req_b;
      end
      // The lock is taken only by the access that actually wins the port.
      if (w_gnt_a && i_lock_a) begin
        w_next_state = LOCK_A;
      end else if (w_gnt_b && i_lock_b) begin
        w_next_state = LOCK_B;
      end
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_data  = '0;
    o_mem_write = 1'b0;
    if (w_gnt_a) begin
      o_mem_addr  = i_addr_a;
      o_mem_data  = i_data_a;
      o_mem_write = i_write_a;
    end else if (w_gnt_b) begin
      o_mem_addr  = i_addr_b;
      o_mem_data  = i_data_b;
      o_mem_write = i_write_b;
    end
  end

  assign o_gnt_a  = w_gnt_a;
  assign o_gnt_b  = w_gnt_b;
  assign o_ack_a  = r_ack_a;
  assign o_ack_b  = r_ack_b;
  assign o_data_a = r_ack_a ? i_mem_data : '0;
  assign o_data_b = r_ack_b ? i_mem_data : '0;

endmodule
